ram_share_arbiter: RTL and testbench
====================================

Name: ram_share_arbiter

Overview:
- Shares one 16x8 scratch RAM between two requesters: port 0 is the CPU load/store unit, port 1 is the host/debug loader.
- Grants one access at a time through a 3-state sequencer and arbitrates round-robin on contention.
- Returns read data with a fixed latency.
- Sits between the CPU core and the scratch RAM; replaces direct RAM indexing in the core.

Parameters:
- AW, 4, address width; RAM depth is 2**AW.
- DW, 8, data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  2  per-port request; bit0 = CPU, bit1 = host.
- we  input  2  per-port write enable, qualified by req.
- addr0  input  AW  CPU address.
- addr1  input  AW  host address.
- wdata0  input  DW  CPU write data.
- wdata1  input  DW  host write data.
- gnt  output  2  one-hot, one-cycle pulse; request accepted.
- done  output  2  one-hot, one-cycle pulse; access complete.
- rdata  output  DW  read data, valid when done is set for a read.
- busy  output  1  sequencer not in IDLE.
- stall_cnt  output  8  wait-cycle counter (see Optional Feature).

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; gnt=0, done=0, rdata=0, busy=0, stall_cnt=0.
  - last_winner=1, so the CPU wins the first tie.
  - All RAM words cleared to 0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE, one cycle each. One transaction per 3 cycles; no pipelining.
- IDLE, with req!=0 sampled at edge N:
  - Winner is the sole requester, or on a tie the port != last_winner.
  - Latch winner, we, addr, wdata.
  - gnt[winner]=1 during cycle N+1; last_winner<=winner; go ACCESS.
  - If req==0, stay in IDLE.
- ACCESS (cycle N+1):
  - Write: RAM[addr]<=wdata at the end of the cycle.
  - Read: rdata_reg<=RAM[addr].
  - Go RESP.
- RESP (cycle N+2):
  - done[winner]=1.
  - rdata holds the read value; for writes rdata is unchanged from its previous value.
  - Go IDLE.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt. Values are captured at the accept edge; later changes are ignored.
  - Dropping req before gnt withdraws the request with no side effect.
  - req held after done is treated as a new request. The earliest re-accept is the IDLE edge following RESP, so a continuous requester gets 1 access per 3 cycles.
- Starvation bound: with both ports continuously requesting, grants alternate 0,1,0,1. Maximum wait is one transaction, 3 cycles, before acceptance.
- Read after write to the same address from either port returns the new data. Accesses are serialised.
- busy=1 in ACCESS and RESP.
- rdata is registered and holds its value until the next read's ACCESS edge.
- Reset mid-transaction: abort immediately.
  - Write aborted in ACCESS: not committed if rst falls before the clock edge.
  - No done pulse is emitted.
  - RAM is cleared.
- Address width: addr is AW bits; all 2**AW words are reachable; no wrap logic needed.

Optional Feature:
- Macro: ARB_STALL_COUNT_EN.
- Defined:
  - stall_cnt increments by 1 on each clock edge where some req bit is set, that port is not being accepted, and the block is not in reset.
  - Saturates at 255.
  - Cleared only by reset.
- Undefined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Single write then read:
  - CPU writes 0xA5 to addr 3: gnt=01 at N+1, done=01 at N+2.
  - CPU then reads addr 3: done=01 with rdata=0xA5 exactly 2 cycles after its gnt edge.
- Simultaneous requests from reset:
  - Both ports read addr 0 and addr 1 continuously.
  - Grant order 0,1,0,1 with gnt pulses 3 cycles apart.
  - With the macro enabled, stall_cnt increments during each loser's wait.
- Withdrawn request:
  - Host raises req while CPU is in ACCESS, then drops it in RESP.
  - No host gnt; RAM unchanged; next IDLE has busy=0.
- Host load, CPU read:
  - Host writes 0x10..0x1F to addr 0..15.
  - CPU reads all 16 addresses; each rdata equals 0x10+addr.
- Reset mid-write:
  - CPU writes 0xFF to addr 7; rst pulled low during ACCESS before the edge.
  - done stays 0; after release, read addr 7 returns 0x00.
- Saturation (macro enabled):
  - Hold host req for 300 contention cycles with CPU always requesting.
  - stall_cnt stops at 255.
  - Macro disabled: stall_cnt reads 0 throughout.

Source files
------------

// File: rtl/ram_share_arbiter_if.sv
// ram_share_arbiter_if: request/response bundle between the two requesters
// and the scratch-RAM arbiter.
//   req[1:0]       per-port request (bit0 CPU, bit1 host)
//   we[1:0]        per-port write enable, qualified by req
//   addr0/addr1    per-port address (AW bits)
//   wdata0/wdata1  per-port write data (DW bits)
//   gnt[1:0]       one-hot accept pulse
//   done[1:0]      one-hot completion pulse
//   rdata          read data, valid with done on a read
//   busy           sequencer outside IDLE
//   stall_cnt      saturating wait-cycle counter (0 unless ARB_STALL_COUNT_EN)
// Modports: master = requester side, slave = arbiter side.
interface ram_share_arbiter_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) ();
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    done;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [7:0]    stall_cnt;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, done, rdata, busy, stall_cnt
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, done, rdata, busy, stall_cnt
  );
endinterface

// File: rtl/ram_share_arbiter.sv
// ram_share_arbiter: shares one 2**AW x DW scratch RAM between the CPU
// load/store unit (port 0) and the host/debug loader (port 1). A 3-state
// sequencer (IDLE -> ACCESS -> RESP) serves one access per 3 cycles with
// round-robin arbitration on contention; read data is registered.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (clears sequencer and whole RAM)
//   bus  ram_share_arbiter_if.slave request/response bundle
// Optional: define ARB_STALL_COUNT_EN to build the saturating stall counter;
// otherwise bus.stall_cnt is tied to zero.
module ram_share_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_share_arbiter_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Transaction captured at the accept edge.
  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  state_e        state_q, state_d;
  txn_t          txn_q, txn_d;
  logic          last_q, last_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          win_c;
  logic          mem_we_c;
  logic [DW-1:0] mem_q [DEPTH];

  // Sole requester wins; on a tie the port that did not win last time.
  assign win_c = (bus.req == 2'b11) ? ~last_q : bus.req[1];

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    last_d   = last_q;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          txn_d.port   = win_c;
          txn_d.we     = bus.we[win_c];
          txn_d.addr   = win_c ? bus.addr1 : bus.addr0;
          txn_d.wdata  = win_c ? bus.wdata1 : bus.wdata0;
          gnt_d[win_c] = 1'b1;
          last_d       = win_c;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (txn_q.we) mem_we_c = 1'b1;
        else          rdata_d  = mem_q[txn_q.addr];
        // done is registered, so it is raised here to show during RESP.
        done_d[txn_q.port] = 1'b1;
        state_d            = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      txn_q   <= '0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Scratch RAM; reset clears every word so an aborted write never lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we_c) begin
      mem_q[txn_q.addr] <= txn_q.wdata;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

`ifdef ARB_STALL_COUNT_EN
  logic [7:0] stall_q, stall_d;
  logic [1:0] acc_mask_c;

  // Count edges where a requesting port is not the one being accepted.
  always_comb begin
    acc_mask_c = 2'b00;
    if (state_q == IDLE && bus.req != 2'b00) acc_mask_c = win_c ? 2'b10 : 2'b01;
    stall_d = stall_q;
    if (((bus.req & ~acc_mask_c) != 2'b00) && (stall_q != 8'hFF))
      stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= 8'd0;
    else      stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_ram_share_arbiter.sv
// tb_ram_share_arbiter: directed bench for ram_share_arbiter. Inputs change
// and outputs are sampled on the falling edge, away from the active edge.
module tb_ram_share_arbiter;

`ifdef ARB_STALL_COUNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ram_share_arbiter_if #(.AW(4), .DW(8)) bus ();

  ram_share_arbiter #(.AW(4), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] stall_exp(input int n);
    return STALL_EN ? 8'(n > 255 ? 255 : n) : 8'd0;
  endfunction

  // One isolated transaction from IDLE back to IDLE; req dropped after gnt.
  task automatic txn(input bit p, input bit w, input logic [3:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
    logic [1:0] oh;
    oh = p ? 2'b10 : 2'b01;
    bus.req = oh;
    bus.we  = w ? oh : 2'b00;
    if (p) begin bus.addr1 = a; bus.wdata1 = d; end
    else   begin bus.addr0 = a; bus.wdata0 = d; end
    tick();
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(oh));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.req = 2'b00;
    tick();
    chk({tag, "_done"}, 32'(bus.done), 32'(oh));
    if (!w) chk({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
    tick();
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    tick(); tick();

    // Reset state
    chk("rst_gnt",   32'(bus.gnt), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.stall_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Single write then read from the CPU
    txn(1'b0, 1'b1, 4'd3, 8'hA5, 8'h00, "cpu_wr3");
    txn(1'b0, 1'b0, 4'd3, 8'h00, 8'hA5, "cpu_rd3");
    chk("wr_rd_stall", 32'(bus.stall_cnt), 32'd0);

    // Simultaneous continuous reads from reset: grants 0,1,0,1
    rst = 1'b0;
    tick();
    bus.we = 2'b00; bus.addr0 = 4'd0; bus.addr1 = 4'd1;
    bus.req = 2'b11;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_stall", 32'(bus.stall_cnt), 32'(stall_exp(3 * k + 1)));
      tick();
      chk("rr_done", 32'(bus.done), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_rdata", 32'(bus.rdata), 32'd0);
      tick();
      chk("rr_idle_gnt", 32'(bus.gnt), 32'd0);
    end
    bus.req = 2'b00;
    tick();
    chk("rr_end_gnt", 32'(bus.gnt), 32'd0);
    chk("rr_end_stall", 32'(bus.stall_cnt), 32'(stall_exp(12)));

    // Withdrawn host request during a CPU write
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 4'd2; bus.wdata0 = 8'h5A;
    tick();
    chk("wd_cpu_gnt", 32'(bus.gnt), 32'd1);
    bus.req = 2'b10; bus.we = 2'b10; bus.addr1 = 4'd2; bus.wdata1 = 8'hEE;
    tick();
    chk("wd_cpu_done", 32'(bus.done), 32'd1);
    bus.req = 2'b00;
    tick();
    chk("wd_idle_busy", 32'(bus.busy), 32'd0);
    chk("wd_idle_gnt", 32'(bus.gnt), 32'd0);
    tick();
    chk("wd_no_gnt", 32'(bus.gnt), 32'd0);
    chk("wd_no_busy", 32'(bus.busy), 32'd0);
    txn(1'b0, 1'b0, 4'd2, 8'h00, 8'h5A, "wd_rd2");

    // Host loads the RAM, CPU reads everything back
    for (int a = 0; a < 16; a++) txn(1'b1, 1'b1, 4'(a), 8'(8'h10 + a), 8'h00, "host_wr");
    for (int a = 0; a < 16; a++) txn(1'b0, 1'b0, 4'(a), 8'h00, 8'(8'h10 + a), "cpu_rd");

    // Reset during the ACCESS cycle of a CPU write
    bus.req = 2'b01; bus.we = 2'b01; bus.addr0 = 4'd7; bus.wdata0 = 8'hFF;
    tick();
    chk("rm_gnt", 32'(bus.gnt), 32'd1);
    rst = 1'b0;
    bus.req = 2'b00;
    #1;
    chk("rm_busy", 32'(bus.busy), 32'd0);
    chk("rm_gnt0", 32'(bus.gnt), 32'd0);
    tick();
    chk("rm_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    tick();
    chk("rm_done_after", 32'(bus.done), 32'd0);
    txn(1'b0, 1'b0, 4'd7, 8'h00, 8'h00, "rm_rd7");
    txn(1'b0, 1'b0, 4'd3, 8'h00, 8'h00, "rm_rd3");
    chk("rm_stall", 32'(bus.stall_cnt), 32'd0);

    // Saturation under continuous contention
    rst = 1'b0;
    tick();
    bus.we = 2'b00; bus.req = 2'b11;
    rst = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("sat_100", 32'(bus.stall_cnt), 32'(stall_exp(100)));
    for (int i = 0; i < 200; i++) tick();
    chk("sat_300", 32'(bus.stall_cnt), 32'(stall_exp(300)));
    bus.req = 2'b00;
    tick(); tick(); tick(); tick();
    chk("sat_hold", 32'(bus.stall_cnt), 32'(stall_exp(300)));
    chk("sat_idle", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
